// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command sequencer: command op codes,
// the ALU-native op subset and the sequencer state encoding.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_AND = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } cmd_op_t;

  // The ALU itself only understands ADD and AND; anything else yields 0.
  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_AND = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } seq_state_t;

endpackage

// File: rtl/alu.sv
// Shared two-op combinational ALU: ADD, AND, every other op gives 0.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] c
);

  always_comb begin
    c = '0;
    case (op)
      ALU_OP_ADD: c = a + b;
      ALU_OP_AND: c = a & b;
      default:    c = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command sequencer driving the shared ALU; MUL is built from WIDTH ADD passes.
// Define ALU_SEQ_OVF_EN to add the res_ovf overflow output.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] alu_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic             busy
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic             res_ovf
`endif
);

  seq_state_t       state_r, state_next;
  cmd_op_t          op_r;
  logic [WIDTH-1:0] a_r, b_r, acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] res_data_r;
  logic             res_err_r;
  logic [WIDTH-1:0] shift_lo;
  logic             mul_last;

`ifdef ALU_SEQ_OVF_EN
  logic [2*WIDTH-1:0] shift_full;
  logic               shift_lost;
  logic               ovf_r;

  // Keep the bits pushed past WIDTH so a dropped partial product is visible.
  assign shift_full = {{WIDTH{1'b0}}, a_r} << cnt_r;
  assign shift_lo   = shift_full[WIDTH-1:0];
  assign shift_lost = |shift_full[2*WIDTH-1:WIDTH];
  assign res_ovf    = ovf_r;
`else
  assign shift_lo = a_r << cnt_r;
`endif

  assign mul_last  = (cnt_r == CNT_W'(WIDTH - 1));
  assign cmd_ready = (state_r == IDLE);
  assign res_valid = (state_r == RESP);
  assign busy      = (state_r != IDLE);
  assign res_data  = res_data_r;
  assign res_err   = res_err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_next;
  end

  always_comb begin
    state_next = state_r;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = ALU_OP_ADD;
    case (state_r)
      IDLE: if (cmd_valid) state_next = EXEC;
      EXEC: begin
        case (op_r)
          OP_ADD, OP_AND: begin
            alu_op     = op_r;
            alu_a      = a_r;
            alu_b      = b_r;
            state_next = RESP;
          end
          OP_MUL: begin
            alu_a = acc_r;
            alu_b = b_r[cnt_r] ? shift_lo : '0;
            if (mul_last) state_next = RESP;
          end
          default: state_next = RESP;
        endcase
      end
      RESP: if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r       <= OP_ADD;
      a_r        <= '0;
      b_r        <= '0;
      acc_r      <= '0;
      cnt_r      <= '0;
      res_data_r <= '0;
      res_err_r  <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: if (cmd_valid) begin
          op_r      <= cmd_op_t'(cmd_op);
          a_r       <= cmd_a;
          b_r       <= cmd_b;
          acc_r     <= '0;
          cnt_r     <= '0;
          res_err_r <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
          ovf_r     <= 1'b0;
`endif
        end
        EXEC: begin
          case (op_r)
            OP_ADD: begin
              res_data_r <= alu_c;
`ifdef ALU_SEQ_OVF_EN
              ovf_r      <= (alu_c < a_r);
`endif
            end
            OP_AND: res_data_r <= alu_c;
            OP_MUL: begin
              acc_r <= alu_c;
              cnt_r <= cnt_r + CNT_W'(1);
              if (mul_last) res_data_r <= alu_c;
`ifdef ALU_SEQ_OVF_EN
              // Carry out of this pass, or a set multiplier bit selecting a truncated partial.
              ovf_r <= ovf_r | (alu_c < acc_r) | (b_r[cnt_r] & shift_lost);
`endif
            end
            default: begin
              res_data_r <= '0;
              res_err_r  <= 1'b1;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: sequencer plus ALU peer, directed plan then random commands
// against an arithmetic reference model. Honours ALU_SEQ_OVF_EN for res_ovf.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_a = '0;
  logic [WIDTH-1:0] cmd_b = '0;
  logic [WIDTH-1:0] alu_a, alu_b, alu_c;
  logic [1:0]       alu_op;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_data;
  logic             res_err;
  logic             busy;
`ifdef ALU_SEQ_OVF_EN
  logic             res_ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err), .busy(busy)
`ifdef ALU_SEQ_OVF_EN
    , .res_ovf(res_ovf)
`endif
  );

  alu #(.WIDTH(WIDTH)) u_alu (
    .a(alu_a), .b(alu_b), .op(alu_op), .c(alu_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    check({tag, ".res_data"},  32'(res_data),  32'd0);
    check({tag, ".res_err"},   32'(res_err),   32'd0);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".alu_a"},     32'(alu_a),     32'd0);
    check({tag, ".alu_b"},     32'(alu_b),     32'd0);
    check({tag, ".alu_op"},    32'(alu_op),    32'd0);
`ifdef ALU_SEQ_OVF_EN
    check({tag, ".res_ovf"},   32'(res_ovf),   32'd0);
`endif
  endtask

  // Full command: accept, wait for the result, stall `hold` cycles, then drain.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int hold);
    int full, lat, busy_cnt, exp_lat;
    logic [7:0] exp_data;
    logic exp_err, exp_ovf;
    case (op)
      2'b00:   full = int'(a) + int'(b);
      2'b01:   full = int'(a & b);
      2'b10:   full = int'(a) * int'(b);
      default: full = 0;
    endcase
    exp_data = full[7:0];
    exp_err  = (op == 2'b11);
    exp_ovf  = (op == 2'b00 || op == 2'b10) && (full > 255);
    exp_lat  = (op == 2'b10) ? WIDTH : 1;

    @(negedge clk);
    check("accept.cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a = 8'($urandom);
    cmd_b = 8'($urandom);
    cmd_op = 2'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (!res_valid && lat < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check("latency",  32'(lat),      32'(exp_lat));
    check("res_data", 32'(res_data), 32'(exp_data));
    check("res_err",  32'(res_err),  32'(exp_err));
`ifdef ALU_SEQ_OVF_EN
    check("res_ovf",  32'(res_ovf),  32'(exp_ovf));
`endif
    for (int i = 0; i < hold; i++) begin
      if (busy) busy_cnt++;
      cmd_valid = 1'b1;
      cmd_op = 2'($urandom);
      @(negedge clk);
      check("hold.res_valid", 32'(res_valid), 32'd1);
      check("hold.res_data",  32'(res_data),  32'(exp_data));
      check("hold.cmd_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    if (busy) busy_cnt++;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("drain.res_valid", 32'(res_valid), 32'd0);
    check("drain.cmd_ready", 32'(cmd_ready), 32'd1);
    check("busy_cycles",     32'(busy_cnt),  32'(exp_lat + 1 + hold));
    $display("txn op=%0d a=%02h b=%02h hold=%0d -> data=%02h err=%0d lat=%0d",
             op, a, b, hold, res_data, res_err, lat);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_reset_outs("reset");
    repeat (2) @(negedge clk);
    check_reset_outs("reset_held");
    rst_n = 1'b1;

    run_cmd(2'b00, 8'h3C, 8'h15, 0);
    run_cmd(2'b00, 8'hF0, 8'h20, 0);
    run_cmd(2'b01, 8'hAA, 8'h0F, 0);
    run_cmd(2'b10, 8'h0D, 8'h0B, 0);
    run_cmd(2'b10, 8'h10, 8'h20, 0);
    run_cmd(2'b00, 8'h81, 8'h7F, 5);
    run_cmd(2'b11, 8'hFF, 8'hFF, 0);
    run_cmd(2'b00, 8'h01, 8'h02, 0);

    // Reset during the fourth MUL pass.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 8'h37; cmd_b = 8'hFF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midmul.busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("midmul_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midmul.no_valid", 32'(res_valid), 32'd0);
    end
    rst_n = 1'b1;
    run_cmd(2'b00, 8'h01, 8'h01, 0);

    for (int i = 0; i < 40; i++) begin
      run_cmd(2'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-driven controller for the shared 2-op ALU (op 00 = ADD, 01 = AND, c = 8-bit result, all other ops give 0).
- Accepts one command at a time over a valid/ready handshake and drives the ALU's a/b/op inputs.
- ADD and AND each take one ALU pass. MUL is done as an 8-pass shift-add sequence using only the ALU's ADD.
- Returns the registered result over a valid/ready handshake. Sits between the instruction decode stage and the ALU instance.

Parameters:
- WIDTH, 8, operand/result width; must equal the ALU width.
- CNT_W, $clog2(WIDTH), width of the MUL iteration counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00 ADD, 01 AND, 10 MUL, 11 reserved
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- alu_a  out  WIDTH  to ALU input a
- alu_b  out  WIDTH  to ALU input b
- alu_op  out  2  to ALU op select
- alu_c  in  WIDTH  from ALU result c (combinational)
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  WIDTH  result
- res_err  out  1  set when the command was the reserved op
- busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE; all registers are 0; cmd_ready = 1; res_valid = 0; res_data = 0; res_err = 0; busy = 0; alu_a = 0; alu_b = 0; alu_op = 00.
- Reset asserted mid-operation aborts the in-flight command; no result is produced.
- State machine: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready: capture op_r, a_r, b_r; set acc = 0 and cnt = 0; go to EXEC.
  - ALU outputs are driven to 0 / op 00.
- EXEC, cmd_ready = 0:
  - ADD/AND: alu_op = op_r, alu_a = a_r, alu_b = b_r. At the clock edge, res_data <= alu_c; go to RESP. Exactly one EXEC cycle.
  - MUL: alu_op = 00, alu_a = acc, alu_b = b_r[cnt] ? (a_r << cnt) truncated to WIDTH : 0.
    - At the clock edge: acc <= alu_c and cnt <= cnt + 1.
    - When cnt == WIDTH-1: res_data <= alu_c; go to RESP.
    - Exactly WIDTH EXEC cycles. Result is the low WIDTH bits of a*b.
  - Reserved (11): no ALU use (outputs 0); res_data <= 0, res_err <= 1; go to RESP after one cycle.
- RESP:
  - res_valid = 1. res_data and res_err are held stable until res_ready.
  - On res_ready: go to IDLE; res_err clears on the next accept.
- Latency (command accepted at edge N):
  - ADD/AND/reserved: res_valid high from cycle N+2.
  - MUL: res_valid high from cycle N+1+WIDTH, i.e. N+9 at WIDTH = 8.
- Throughput:
  - No new command is accepted in the cycle res_ready is sampled; next accept is the following cycle (IDLE).
  - Peak rate is one ADD/AND per 3 cycles.
- Arithmetic: all wrap modulo 2^WIDTH. Shift bits beyond WIDTH are discarded.
- Boundary cases:
  - cmd_valid is ignored outside IDLE.
  - Operand changes after the accept have no effect.
  - res_ready while res_valid = 0 is ignored.

Optional Feature:
- Macro: ALU_SEQ_OVF_EN.
- When defined, an extra output res_ovf (1 bit) is added, valid with res_valid.
  - ADD: res_ovf = carry out, detected as alu_c < alu_a.
  - MUL: res_ovf is the sticky OR, over all passes, of the per-pass carry and of any a_r bit shifted out while b_r[cnt] = 1.
  - AND/reserved: res_ovf = 0.
  - Clears on accept and on reset.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - op codes OP_ADD = 2'b00, OP_AND = 2'b01, OP_MUL = 2'b10, OP_RSV = 2'b11
  - the ALU-native subset used on alu_op
  - seq_state_t enum {IDLE, EXEC, RESP}
- No sub-module inside the sequencer; the ALU stays a separate peer instance wired at the parent level.
- The bench instantiates sequencer + ALU together.

Test Plan:
- ADD: a=0x3C, b=0x15 -> res_data=0x51, res_err=0; res_valid exactly 2 cycles after accept. With OVF_EN: a=0xF0, b=0x20 -> res_data=0x10, res_ovf=1.
- AND: a=0xAA, b=0x0F -> res_data=0x0A, 1 EXEC cycle, busy high 2 cycles.
- MUL: a=0x0D, b=0x0B -> res_data=0x8F after 8 EXEC cycles. a=0x10, b=0x20 -> res_data=0x00, res_ovf=1 (OVF_EN).
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_data stable, cmd_ready=0, a new cmd_valid is ignored; release -> one transfer, then IDLE.
- Reserved op 11: a=0xFF, b=0xFF -> res_data=0x00, res_err=1; the next ADD clears res_err.
- Reset mid-MUL: drop rst_n at EXEC cycle 4 -> all outputs at reset values immediately, no res_valid. After release, ADD 1+1 -> 0x02.
